// File: rtl/ad9866_cmd_arb.sv
// Round-robin arbiter that shares the single AD9866 command slave port among NREQ requesters.
// Each granted command is held on the slave bus until it is acknowledged or the wait counter expires.
module ad9866_cmd_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*6-1:0]    req_addr,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [5:0]           cmd_addr,
  output logic [31:0]          cmd_data,
  output logic                 cmd_rqst,
  input  logic                 cmd_ack,
  output logic                 busy
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   r_rr;
  logic [RW-1:0]   r_gnt;
  logic [RW-1:0]   w_gnt_idx;
  logic [RW-1:0]   w_rr_adv;
  logic [RW-1:0]   w_rr_nxt;
  logic            w_gnt_found;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic            r_rqst;
  logic            w_rqst_nxt;
  logic            w_load;
  logic [5:0]      r_addr;
  logic [31:0]     r_data;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] r_err;
  logic [NREQ-1:0] w_done_nxt;
  logic [NREQ-1:0] w_err_nxt;
  logic            w_expired;

  function automatic logic [RW-1:0] f_wrap(input int v);
    return RW'((v >= NREQ) ? v - NREQ : v);
  endfunction

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = r_rr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_found && req_valid[f_wrap(int'(r_rr) + k)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = f_wrap(int'(r_rr) + k);
      end
    end
  end

  assign w_rr_adv  = f_wrap(int'(r_gnt) + 1);
  assign w_expired = (r_cnt == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (cmd_ack || w_expired) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ack is ignored in ISSUE: it still reflects the slave's verdict on the previous command.
  always_comb begin
    w_load     = 1'b0;
    w_rqst_nxt = r_rqst;
    w_cnt_nxt  = r_cnt;
    w_rr_nxt   = r_rr;
    w_done_nxt = '0;
    w_err_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_load     = 1'b1;
          w_rqst_nxt = 1'b1;
          w_cnt_nxt  = 8'd0;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt = 8'd1;
      end
      S_WAIT: begin
        if (cmd_ack) begin
          w_done_nxt[r_gnt] = 1'b1;
          w_rqst_nxt        = 1'b0;
          w_rr_nxt          = w_rr_adv;
        end else if (w_expired) begin
          w_err_nxt[r_gnt] = 1'b1;
          w_rqst_nxt       = 1'b0;
          w_rr_nxt         = w_rr_adv;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rqst <= 1'b0;
      r_cnt  <= 8'd0;
      r_rr   <= '0;
      r_gnt  <= '0;
      r_done <= '0;
      r_err  <= '0;
      r_addr <= 6'd0;
      r_data <= 32'd0;
    end else begin
      r_rqst <= w_rqst_nxt;
      r_cnt  <= w_cnt_nxt;
      r_rr   <= w_rr_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (w_load) begin
        r_gnt  <= w_gnt_idx;
        r_addr <= req_addr[int'(w_gnt_idx)*6 +: 6];
        r_data <= req_data[int'(w_gnt_idx)*32 +: 32];
      end
    end
  end

  assign cmd_rqst = r_rqst;
  assign cmd_addr = r_addr;
  assign cmd_data = r_data;
  assign req_done = r_done;
  assign req_err  = r_err;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ad9866_cmd_arb.sv
// Bench for ad9866_cmd_arb: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a timeline-based transaction model.
module tb_ad9866_cmd_arb;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 12;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*6-1:0]   req_addr;
  logic [NREQ*32-1:0]  req_data;
  logic [NREQ-1:0]     req_done;
  logic [NREQ-1:0]     req_err;
  logic [5:0]          cmd_addr;
  logic [31:0]         cmd_data;
  logic                cmd_rqst;
  logic                cmd_ack;
  logic                busy;

  ad9866_cmd_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_done(req_done), .req_err(req_err),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rqst(cmd_rqst),
    .cmd_ack(cmd_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  bit     auto_drop = 1'b0;

  // Transaction model: a command granted in cycle t0 is in ISSUE at t0+1 and in its
  // w-th wait cycle at t0+1+w; after a decision in cycle t the arbiter is free again at t+2.
  bit              m_active;
  int              m_g;
  int              m_rr;
  longint          m_t0;
  longint          m_next_arb;
  logic            e_rqst;
  logic            e_busy;
  logic [5:0]      e_addr;
  logic [31:0]     e_data;
  logic [NREQ-1:0] e_done;
  logic [NREQ-1:0] e_err;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active   = 1'b0;
    m_g        = 0;
    m_rr       = 0;
    m_t0       = 0;
    m_next_arb = 0;
    e_rqst     = 1'b0;
    e_busy     = 1'b0;
    e_addr     = '0;
    e_data     = '0;
    e_done     = '0;
    e_err      = '0;
  endtask

  task automatic model_step();
    longint age;
    bit     found;
    e_done = '0;
    e_err  = '0;
    if (m_active) begin
      age = cyc - m_t0;
      if (age >= 2 && (cmd_ack || (age - 1) == TIMEOUT)) begin
        if (cmd_ack) e_done[m_g] = 1'b1;
        else         e_err[m_g]  = 1'b1;
        e_rqst     = 1'b0;
        m_rr       = (m_g + 1) % NREQ;
        m_active   = 1'b0;
        m_next_arb = cyc + 2;
      end
    end else if (cyc >= m_next_arb && req_valid != '0) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req_valid[(m_rr + k) % NREQ]) begin
          found = 1'b1;
          m_g   = (m_rr + k) % NREQ;
        end
      end
      m_active = 1'b1;
      m_t0     = cyc;
      e_rqst   = 1'b1;
      e_addr   = req_addr[m_g*6 +: 6];
      e_data   = req_data[m_g*32 +: 32];
    end
    e_busy = m_active || (cyc + 1 < m_next_arb);
  endtask

  // Apply current inputs for one clock and compare every output against the model.
  task automatic step();
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("ctrl{rqst,busy,done,err}", 64'({cmd_rqst, busy, req_done, req_err}),
        64'({e_rqst, e_busy, e_done, e_err}));
    chk("bus{addr,data}", 64'({cmd_addr, cmd_data}), 64'({e_addr, e_data}));
    if (auto_drop) req_valid = req_valid & ~(e_done | e_err);
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [31:0] d);
    req_addr[i*6 +: 6]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d_idx[$];
    int d_step[$];
    int first_done;
    int err_step;
    int err_idx;
    int regrant_step;
    int n_done;

    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    cmd_ack   = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({cmd_rqst, busy, req_done, req_err, cmd_addr, cmd_data}), 64'd0);
    rst_n = 1'b1;

    // Round robin: everyone valid, ack always high.
    for (int i = 0; i < NREQ; i++) set_req(i, 6'(6'h10 + i), 32'hA000_0000 + 32'(i));
    cmd_ack   = 1'b1;
    req_valid = '1;
    auto_drop = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      step();
      if (req_done != '0) begin
        d_idx.push_back(onehot_idx(req_done));
        d_step.push_back(s);
      end
    end
    chk("rr_done_count", 64'(d_idx.size()), 64'd5);
    n = (d_idx.size() < 5) ? d_idx.size() : 5;
    for (int k = 0; k < n; k++) begin
      chk("rr_grant_order", 64'(d_idx[k]), 64'(k % NREQ));
      chk("rr_done_step", 64'(d_step[k]), 64'(3 + 4 * k));
    end
    req_valid = '0;
    cmd_ack   = 1'b0;
    repeat (2) step();

    // Single request on requester 2, ack on the second request cycle.
    set_req(2, 6'h0a, 32'h0000_0045);
    req_valid = 4'b0100;
    step();
    chk("single_issue_rqst", 64'(cmd_rqst), 64'd1);
    chk("single_addr", 64'(cmd_addr), 64'h0a);
    chk("single_data", 64'(cmd_data), 64'h45);
    step();
    chk("single_no_early_done", 64'(req_done), 64'd0);
    cmd_ack = 1'b1;
    step();
    chk("single_done", 64'(req_done), 64'b0100);
    chk("single_rqst_low", 64'(cmd_rqst), 64'd0);
    req_valid = '0;
    cmd_ack   = 1'b0;
    step();
    chk("single_done_one_cycle", 64'(req_done), 64'd0);
    step();

    // Wrap: pointer is now 3, requesters 1 and 3 valid.
    set_req(1, 6'h21, 32'h0000_1111);
    set_req(3, 6'h23, 32'h0000_3333);
    req_valid = 4'b1010;
    cmd_ack   = 1'b1;
    auto_drop = 1'b1;
    step();
    chk("wrap_first_grant", 64'(cmd_addr), 64'h23);
    repeat (3) step();
    step();
    chk("wrap_second_grant", 64'(cmd_addr), 64'h21);
    repeat (3) step();
    chk("wrap_all_served", 64'(req_valid), 64'd0);

    // Stale ack: ack high through ISSUE, low for 10 wait cycles, then high.
    set_req(0, 6'h05, 32'hDEAD_BEEF);
    req_valid  = 4'b0001;
    first_done = -1;
    n          = 0;
    for (int j = 0; j <= 14; j++) begin
      cmd_ack = (j <= 1 || j >= 12);
      step();
      if (req_done[0] && first_done < 0) first_done = j + 1;
      if (req_err != '0) n++;
    end
    chk("stale_done_step", 64'(first_done), 64'd13);
    chk("stale_no_err", 64'(n), 64'd0);
    cmd_ack = 1'b0;
    step();

    // Timeout: ack stuck low, requesters 1 and 2 pending; pointer is 1.
    set_req(1, 6'h31, 32'h0000_0031);
    set_req(2, 6'h32, 32'h0000_0032);
    req_valid    = 4'b0110;
    err_step     = -1;
    err_idx      = -1;
    regrant_step = -1;
    n_done       = 0;
    for (int s = 1; s <= 32; s++) begin
      step();
      if (req_err != '0 && err_step < 0) begin
        err_step = s;
        err_idx  = onehot_idx(req_err);
      end
      if (cmd_rqst && cmd_addr == 6'h32 && regrant_step < 0) regrant_step = s;
      if (req_done != '0) n_done++;
    end
    chk("timeout_err_step", 64'(err_step), 64'(TIMEOUT + 2));
    chk("timeout_err_idx", 64'(err_idx), 64'd1);
    chk("timeout_next_grant_step", 64'(regrant_step), 64'(TIMEOUT + 4));
    chk("timeout_no_done", 64'(n_done), 64'd0);
    req_valid = '0;
    repeat (2) step();

    // Reset in the middle of WAIT: pointer 3 grants 3, after reset 1 wins.
    set_req(1, 6'h31, 32'h0000_0131);
    set_req(3, 6'h33, 32'h0000_0133);
    req_valid = 4'b1010;
    cmd_ack   = 1'b0;
    step();
    chk("rst_pre_grant", 64'(cmd_addr), 64'h33);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 64'({cmd_rqst, busy, req_done, req_err, cmd_addr, cmd_data}), 64'd0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_regrant_from_zero", 64'({cmd_rqst, cmd_addr}), 64'({1'b1, 6'h31}));
    cmd_ack = 1'b1;
    repeat (10) step();
    chk("rst_all_served", 64'(req_valid), 64'd0);

    // Randomized traffic across several ack densities.
    for (int ph = 0; ph < 3; ph++) begin
      int pct;
      pct = (ph == 0) ? 70 : (ph == 1) ? 20 : 3;
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
            set_req(i, 6'($urandom), $urandom);
            req_valid[i] = 1'b1;
          end else if (req_valid[i] && $urandom_range(0, 199) == 0) begin
            req_valid[i] = 1'b0;
          end
        end
        cmd_ack = ($urandom_range(0, 99) < pct);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
